// File: rtl/dr_insp_pipe.sv
// dr_insp_pipe: two-stage valid/ready inspector that resolves a column-matched prediction and flags mispredictions with hold-off.
// Optional: define DR_INSP_FLUSH_CNT_EN to add a saturating 16-bit flush_cnt output.
module dr_insp_pipe #(
  parameter int OFF_W   = 32,
  parameter int COL_W   = 16,
  parameter int LANES   = 2,
  parameter int HOLDOFF = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*OFF_W-1:0] in_off,
  input  logic [LANES*COL_W-1:0] in_col,
  input  logic [OFF_W-1:0]       in_pred,
  input  logic [COL_W-1:0]       in_pred_col,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFF_W-1:0]       out_pred,
  output logic [COL_W-1:0]       out_pred_col,
  output logic                   flush
`ifdef DR_INSP_FLUSH_CNT_EN
  ,
  output logic [15:0]            flush_cnt
`endif
);

  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLDOFF);

  logic                   s1_valid_q;
  logic [LANES*OFF_W-1:0] s1_off_q;
  logic [LANES*COL_W-1:0] s1_col_q;
  logic [OFF_W-1:0]       s1_pred_q;
  logic [COL_W-1:0]       s1_pcol_q;

  logic                   out_valid_q;
  logic [OFF_W-1:0]       out_pred_q;
  logic [COL_W-1:0]       out_col_q;
  logic                   flush_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic             s1_load;
  logic             s2_load;
  logic             hit_found;
  logic [OFF_W-1:0] hit_off;
  logic [COL_W-1:0] hit_col;
  logic [OFF_W-1:0] res_pred;
  logic [COL_W-1:0] res_col;
  logic             raw_flush;
  logic             flush_d;

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Lowest-index matching lane wins; later lanes are ignored.
  always_comb begin
    hit_found = 1'b0;
    hit_off   = '0;
    hit_col   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!hit_found &&
          s1_col_q[i*COL_W +: COL_W] == s1_pcol_q) begin
        hit_found = 1'b1;
        hit_off   = s1_off_q[i*OFF_W +: OFF_W];
        hit_col   = s1_col_q[i*COL_W +: COL_W];
      end
    end
  end

  always_comb begin
    res_pred  = s1_pred_q;
    res_col   = s1_pcol_q;
    raw_flush = 1'b0;
    if (hit_found) begin
      res_pred  = hit_off;
      res_col   = hit_col;
      raw_flush = (hit_off != s1_pred_q);
    end
  end

  always_comb begin
    flush_d = raw_flush && (cnt_q == '0);
    cnt_d   = cnt_q;
    if (flush_d) begin
      cnt_d = HOLD_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_off_q   <= '0;
      s1_col_q   <= '0;
      s1_pred_q  <= '0;
      s1_pcol_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_off_q   <= in_off;
        s1_col_q   <= in_col;
        s1_pred_q  <= in_pred;
        s1_pcol_q  <= in_pred_col;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_pred_q  <= '0;
      out_col_q   <= '0;
      flush_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_pred_q  <= res_pred;
        out_col_q   <= res_col;
        flush_q     <= flush_d;
        cnt_q       <= cnt_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pred     = out_pred_q;
  assign out_pred_col = out_col_q;
  assign flush        = flush_q;

`ifdef DR_INSP_FLUSH_CNT_EN
  logic [15:0] fcnt_q;

  // Only consumed, unmasked flushes are counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
    end else if (out_valid_q && out_ready && flush_q &&
                 fcnt_q != 16'hFFFF) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign flush_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_dr_insp_pipe.sv
// tb_dr_insp_pipe: table vectors, directed hold-off/backpressure/reset sequences
// and a randomized stream checked against a scoreboard model.
module tb_dr_insp_pipe;

  localparam int OW = 32;
  localparam int CW = 16;
  localparam int LN = 2;
  localparam int HO = 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [LN*OW-1:0] in_off;
  logic [LN*CW-1:0] in_col;
  logic [OW-1:0]  in_pred;
  logic [CW-1:0]  in_pred_col;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  out_pred;
  logic [CW-1:0]  out_pred_col;
  logic           flush;
`ifdef DR_INSP_FLUSH_CNT_EN
  logic [15:0]    flush_cnt;
`endif

  dr_insp_pipe #(
    .OFF_W(OW), .COL_W(CW), .LANES(LN), .HOLDOFF(HO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_off(in_off), .in_col(in_col),
    .in_pred(in_pred), .in_pred_col(in_pred_col),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pred(out_pred), .out_pred_col(out_pred_col),
    .flush(flush)
`ifdef DR_INSP_FLUSH_CNT_EN
    , .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LN*OW-1:0] off;
    logic [LN*CW-1:0] col;
    logic [OW-1:0]    pred;
    logic [CW-1:0]    pcol;
  } beat_t;

  typedef struct {
    logic [OW-1:0] pred;
    logic [CW-1:0] col;
    logic          fl;
  } exp_t;

  typedef struct {
    beat_t b;
    exp_t  e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   mdl_cnt = 0;
  int   mdl_fc  = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: lowest matching lane decides; hold-off counts loaded beats.
  function automatic exp_t model(input beat_t b);
    exp_t r;
    int   h;
    logic raw;
    h   = -1;
    raw = 1'b0;
    for (int i = 0; i < LN; i++)
      if (h < 0 && b.col[i*CW +: CW] == b.pcol) h = i;
    r.pred = b.pred;
    r.col  = b.pcol;
    if (h >= 0) begin
      r.pred = b.off[h*OW +: OW];
      r.col  = b.col[h*CW +: CW];
      raw    = (r.pred != b.pred);
    end
    r.fl = raw && (mdl_cnt == 0);
    if (r.fl) mdl_cnt = HO;
    else if (mdl_cnt > 0) mdl_cnt--;
    return r;
  endfunction

  // Monitor: handshakes as they will occur on the next rising edge.
  initial begin
    logic          stall;
    logic [OW-1:0] h_pred;
    logic [CW-1:0] h_col;
    logic          h_fl;
    beat_t         b;
    exp_t          e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall && out_valid)
          chk("stall_hold", {out_pred, out_pred_col, flush},
              {h_pred, h_col, h_fl});
        stall  = out_valid && !out_ready;
        h_pred = out_pred;
        h_col  = out_pred_col;
        h_fl   = flush;
        if (out_valid && out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", {out_pred, out_pred_col, flush},
                {e.pred, e.col, e.fl});
          end
          if (flush && mdl_fc < 16'hFFFF) mdl_fc++;
        end
        if (in_valid && in_ready) begin
          acc_cnt++;
          b.off  = in_off;
          b.col  = in_col;
          b.pred = in_pred;
          b.pcol = in_pred_col;
          exp_q.push_back(model(b));
        end
      end
    end
  end

  task automatic drive(input beat_t b);
    in_off      = b.off;
    in_col      = b.col;
    in_pred     = b.pred;
    in_pred_col = b.pcol;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b0;
    exp_q.delete();
    mdl_cnt = 0;
    mdl_fc  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input beat_t b);
    logic acc;
    int   g;
    drive(b);
    in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 300);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef DR_INSP_FLUSH_CNT_EN
    chk("flush_cnt", 64'(flush_cnt), 64'(mdl_fc));
`endif
  endtask

  function automatic beat_t mk(input logic [OW-1:0] o0, input logic [CW-1:0] c0,
                               input logic [OW-1:0] o1, input logic [CW-1:0] c1,
                               input logic [OW-1:0] p, input logic [CW-1:0] pc);
    beat_t b;
    b.off  = {o1, o0};
    b.col  = {c1, c0};
    b.pred = p;
    b.pcol = pc;
    return b;
  endfunction

  function automatic exp_t ex(input logic [OW-1:0] p, input logic [CW-1:0] c,
                              input logic f);
    exp_t e;
    e.pred = p;
    e.col  = c;
    e.fl   = f;
    return e;
  endfunction

  vec_t  vt[6];
  beat_t bq[6];
  logic  fl_seen[4];
  logic [OW-1:0] pr_seen[4];

  initial begin
    int n;
    rst         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_off      = '0;
    in_col      = '0;
    in_pred     = '0;
    in_pred_col = '0;

    vt[0] = '{mk(32'h100, 16'd5, 32'h200, 16'd7, 32'h100, 16'd5), ex(32'h100, 16'd5, 1'b0)};
    vt[1] = '{mk(32'h300, 16'd5, 32'h400, 16'd5, 32'h100, 16'd5), ex(32'h300, 16'd5, 1'b1)};
    vt[2] = '{mk(32'h11, 16'd1, 32'h22, 16'd2, 32'h55, 16'd9), ex(32'h55, 16'd9, 1'b0)};
    vt[3] = '{mk(32'h11, 16'd1, 32'h77, 16'd9, 32'h55, 16'd9), ex(32'h77, 16'd9, 1'b1)};
    vt[4] = '{mk(32'h500, 16'd3, 32'h600, 16'd3, 32'h500, 16'd3), ex(32'h500, 16'd3, 1'b0)};
    vt[5] = '{mk(32'h1, 16'd4, 32'hABC, 16'd8, 32'hABC, 16'd8), ex(32'hABC, 16'd8, 1'b0)};

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pred", 64'(out_pred), 64'd0);
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Table vectors: one beat each, two edges from presentation to output.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      out_ready = 1'b1;
      drive(vt[k].b);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("vec_lat1_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_out", {out_pred, out_pred_col, flush},
          {vt[k].e.pred, vt[k].e.col, vt[k].e.fl});
      wait_drain();
    end

    // Hold-off window of two beats: flush pattern 1,0,0,1.
    do_reset();
    out_ready = 1'b1;
    n = 0;
    for (int j = 0; j < 4; j++) begin
      drive(mk(32'h300 + 32'(j*16), 16'd5, 32'h999, 16'd5, 32'h100, 16'd5));
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid && n < 4) begin
        fl_seen[n] = flush; pr_seen[n] = out_pred; n++;
      end
    end
    in_valid = 1'b0;
    for (int g = 0; g < 20 && n < 4; g++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        fl_seen[n] = flush; pr_seen[n] = out_pred; n++;
      end
    end
    chk("holdoff_count", 64'(n), 64'd4);
    chk("holdoff_flush", {60'd0, fl_seen[0], fl_seen[1], fl_seen[2], fl_seen[3]},
        64'b1001);
    for (int j = 0; j < 4; j++)
      chk("holdoff_pred", 64'(pr_seen[j]), 64'(32'h300 + 32'(j*16)));
    wait_drain();

    // Backpressure: six beats against a stalled consumer.
    do_reset();
    for (int j = 0; j < 6; j++)
      bq[j] = mk(32'h1000 + 32'(j), 16'(j), 32'h2000 + 32'(j), 16'd2, 32'h2000 + 32'(j), 16'd2);
    acc_cnt = 0;
    out_cnt = 0;
    out_ready = 1'b0;
    fork
      for (int j = 0; j < 6; j++) send(bq[j]);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", 64'(acc_cnt), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_out_count", 64'(out_cnt), 64'd6);

    // Reset with both stages full; hold-off window must be cancelled.
    do_reset();
    out_ready = 1'b0;
    send(mk(32'h300, 16'd5, 32'h0, 16'd0, 32'h100, 16'd5));
    send(mk(32'h310, 16'd5, 32'h0, 16'd0, 32'h100, 16'd5));
    chk("mid_flush_pre", 64'(flush), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_flush", 64'(flush), 64'd0);
    chk("mid_out_pred", {out_pred, out_pred_col}, 64'd0);
    exp_q.delete();
    mdl_cnt = 0;
    mdl_fc  = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(mk(32'h320, 16'd5, 32'h0, 16'd0, 32'h100, 16'd5));
    @(posedge clk);
    #1;
    chk("mid_flush_after", 64'(flush), 64'd1);
    wait_drain();

    // Randomized stream with random gaps and random consumer stalls.
    do_reset();
    begin
      logic done;
      logic [OW-1:0] pool[3];
      pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300;
      done = 1'b0;
      fork
        begin
          for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send(mk(pool[$urandom_range(0, 2)], 16'($urandom_range(0, 3)),
                    pool[$urandom_range(0, 2)], 16'($urandom_range(0, 3)),
                    pool[$urandom_range(0, 2)], 16'($urandom_range(0, 3))));
          end
          done = 1'b1;
        end
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      join
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
